// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller driving per-latch writeEN/flush and pc_en.
// Optional macro HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   ihit, dhit             imem valid / dmem access complete
//   exmem_dmem_req         exmem latch holds a load or store
//   idex_dMemREN           idex latch holds a load
//   idex_writeReg          destination register of the idex instruction
//   ifid_rs, ifid_rt       source registers of the ifid instruction
//   redirect               taken branch / jump resolved in MEM
//   memwb_halt             halt reached memwb
//   pc_en                  PC load enable
//   <latch>_writeEN/_flush load enable / sync clear for ifid, idex, exmem, memwb
//   halted                 sticky halt status
//   stall_cnt, flush_cnt   performance counters (HAZARD_PERF_EN only)
module hazard_ctrl #(
   parameter int REG_W  = 5,
   parameter int PERF_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dmem_req,
   input  logic             idex_dMemREN,
   input  logic [REG_W-1:0] idex_writeReg,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             redirect,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_writeEN,
   output logic             ifid_flush,
   output logic             idex_writeEN,
   output logic             idex_flush,
   output logic             exmem_writeEN,
   output logic             exmem_flush,
   output logic             memwb_writeEN,
   output logic             memwb_flush,
   output logic             halted
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      REDIR  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   load_use;
   logic   dmem_wait;
   logic   redir_take;

   assign load_use = idex_dMemREN
                   && (idex_writeReg != '0)
                   && ((idex_writeReg == ifid_rs)
                    || (idex_writeReg == ifid_rt));
   assign dmem_wait = exmem_dmem_req && !dhit;

   always_comb begin
      state_d       = state_q;
      redir_take    = 1'b0;
      pc_en         = 1'b0;
      ifid_writeEN  = 1'b0;
      ifid_flush    = 1'b0;
      idex_writeEN  = 1'b0;
      idex_flush    = 1'b0;
      exmem_writeEN = 1'b0;
      exmem_flush   = 1'b0;
      memwb_writeEN = 1'b0;
      memwb_flush   = 1'b0;
      // Outputs are combinational, so they are forced low while in reset.
      if (!nRST) begin
         state_d = RUN;
      end else if (state_q == HALTED || memwb_halt) begin
         state_d = HALTED;
      end else if (dmem_wait) begin
         // Whole pipe frozen; a pending redirect stays in exmem until dhit.
         state_d = state_q;
      end else if (redirect) begin
         redir_take    = 1'b1;
         pc_en         = 1'b1;
         ifid_writeEN  = 1'b1;
         ifid_flush    = 1'b1;
         idex_writeEN  = 1'b1;
         idex_flush    = 1'b1;
         exmem_writeEN = 1'b1;
         exmem_flush   = 1'b1;
         memwb_writeEN = 1'b1;
         state_d       = ihit ? RUN : REDIR;
      end else if (state_q == REDIR) begin
         idex_writeEN  = 1'b1;
         exmem_writeEN = 1'b1;
         memwb_writeEN = 1'b1;
         if (ihit) begin
            // Fetch of the redirect target has returned.
            pc_en        = 1'b1;
            ifid_writeEN = 1'b1;
            state_d      = RUN;
         end else begin
            ifid_flush = 1'b1;
         end
      end else if (load_use) begin
         // ifid holds; the flushed idex becomes a non-load next cycle.
         idex_writeEN  = 1'b1;
         idex_flush    = 1'b1;
         exmem_writeEN = 1'b1;
         memwb_writeEN = 1'b1;
      end else if (!ihit) begin
         ifid_flush    = 1'b1;
         idex_writeEN  = 1'b1;
         exmem_writeEN = 1'b1;
         memwb_writeEN = 1'b1;
      end else begin
         pc_en         = 1'b1;
         ifid_writeEN  = 1'b1;
         idex_writeEN  = 1'b1;
         exmem_writeEN = 1'b1;
         memwb_writeEN = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state_q <= RUN;
      else       state_q <= state_d;
   end

   assign halted = (state_q == HALTED);

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en && state_q != HALTED) stall_cnt_d = stall_cnt_q + 1'b1;
      if (redir_take)                  flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl.
// Output vector order: pc_en, ifid we/fl, idex we/fl, exmem we/fl, memwb we/fl, halted.
module tb_hazard_ctrl;
   localparam int REG_W  = 5;
   localparam int PERF_W = 32;

   localparam logic [9:0] V_ZERO = 10'b0000000000;
   localparam logic [9:0] V_RUN  = 10'b1101010100;
   localparam logic [9:0] V_LU   = 10'b0001110100;
   localparam logic [9:0] V_RED  = 10'b1111111100;
   localparam logic [9:0] V_WAIT = 10'b0011010100;
   localparam logic [9:0] V_HALT = 10'b0000000001;

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             ihit, dhit, exmem_dmem_req, idex_dMemREN;
   logic [REG_W-1:0] idex_writeReg, ifid_rs, ifid_rt;
   logic             redirect, memwb_halt;
   logic             pc_en, ifid_writeEN, ifid_flush;
   logic             idex_writeEN, idex_flush;
   logic             exmem_writeEN, exmem_flush;
   logic             memwb_writeEN, memwb_flush, halted;
`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl #(.REG_W(REG_W), .PERF_W(PERF_W)) dut (
      .CLK(CLK), .nRST(nRST),
      .ihit(ihit), .dhit(dhit),
      .exmem_dmem_req(exmem_dmem_req),
      .idex_dMemREN(idex_dMemREN),
      .idex_writeReg(idex_writeReg),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .redirect(redirect), .memwb_halt(memwb_halt),
      .pc_en(pc_en),
      .ifid_writeEN(ifid_writeEN), .ifid_flush(ifid_flush),
      .idex_writeEN(idex_writeEN), .idex_flush(idex_flush),
      .exmem_writeEN(exmem_writeEN), .exmem_flush(exmem_flush),
      .memwb_writeEN(memwb_writeEN), .memwb_flush(memwb_flush),
      .halted(halted)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   wire [9:0] outv = {pc_en, ifid_writeEN, ifid_flush,
                      idex_writeEN, idex_flush,
                      exmem_writeEN, exmem_flush,
                      memwb_writeEN, memwb_flush, halted};

   int checks   = 0;
   int failures = 0;
   int m_stall  = 0;
   int m_flush  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic ih, input logic dh, input logic dq,
                         input logic dr, input logic [REG_W-1:0] wr,
                         input logic [REG_W-1:0] rs,
                         input logic [REG_W-1:0] rt,
                         input logic rd, input logic hl);
      @(negedge CLK);
      ihit = ih; dhit = dh; exmem_dmem_req = dq;
      idex_dMemREN = dr; idex_writeReg = wr;
      ifid_rs = rs; ifid_rt = rt;
      redirect = rd; memwb_halt = hl;
   endtask

   // Check outputs mid-cycle, then advance the counter model for the
   // coming rising edge.
   task automatic step(input string tag, input logic [9:0] exp);
      #1;
      chk(tag, {22'd0, outv}, {22'd0, exp});
`ifdef HAZARD_PERF_EN
      chk({tag, "_scnt"}, stall_cnt, m_stall);
      chk({tag, "_fcnt"}, flush_cnt, m_flush);
`endif
      if (nRST) begin
         if (!exp[9] && !exp[0]) m_stall++;
         if (exp == V_RED)       m_flush++;
      end
   endtask

   task automatic idle(input string tag);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(tag, V_RUN);
   endtask

   initial begin
      ihit = 1; dhit = 0; exmem_dmem_req = 0; idex_dMemREN = 0;
      idex_writeReg = 0; ifid_rs = 0; ifid_rt = 0;
      redirect = 0; memwb_halt = 0;

      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("rst0", V_ZERO);
      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step("rst_redir", V_ZERO);

      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1;
      step("first_run", V_RUN);

      set_in(1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0);
      step("lu_rt", V_LU);
      idle("lu_after");
      set_in(1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 0);
      step("lu_rs", V_LU);
      set_in(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
      step("lu_r0", V_RUN);
      set_in(1, 0, 0, 1, 5'd3, 5'd4, 5'd6, 0, 0);
      step("lu_nodep", V_RUN);

      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
         step($sformatf("dwait%0d", i), V_ZERO);
      end
      set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step("dhit", V_RUN);

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("iwait", V_WAIT);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("redir", V_RED);
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
         step($sformatf("redir_wait%0d", i), V_WAIT);
      end
      set_in(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
      step("redir_ihit", V_RUN);
      idle("redir_done");

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("redir_a", V_RED);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("redir_restart", V_RED);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("redir_b", V_WAIT);
      idle("redir_b_end");

      set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step("redir_hit", V_RED);
      idle("redir_hit_run");

      set_in(1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
      step("redir_lu", V_RED);
      idle("redir_lu_run");

      set_in(1, 0, 1, 0, 0, 0, 0, 1, 0);
      step("redir_dwait", V_ZERO);
      set_in(1, 1, 1, 0, 0, 0, 0, 1, 0);
      step("redir_dhit", V_RED);
      idle("redir_dhit_run");

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("mid_redir_a", V_RED);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("mid_redir_b", V_WAIT);
      nRST = 0;
      m_stall = 0;
      m_flush = 0;
      step("mid_redir_rst", V_ZERO);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      nRST = 1;
      step("post_rst_run", V_RUN);

      set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
      step("halt_pulse", V_ZERO);
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 0, 0, 0, 0, 0, i == 1, 0);
         step($sformatf("halted%0d", i), V_HALT);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
